// File: rtl/chip_valve_sequencer.sv
// Valve-control sequencer for the N-chamber ChIP chip.
// Takes one fluidic operation at a time over a valid/ready port and drives
// the pneumatic control lines. Valve polarity: 1 = pressurised = closed.
module chip_valve_sequencer #(
    parameter int N_INLETS      = 5,
    parameter int N_CHAMBERS    = 10,
    parameter int CNT_W         = 16,
    parameter int PHASE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [7:0]            cmd_sel,
    input  logic [CNT_W-1:0]      cmd_count,
    input  logic                  abort,
    output logic [N_INLETS-1:0]   inlet_ctrl,
    output logic                  prep_inlet_ctrl,
    output logic                  prep_outlet_ctrl,
    output logic                  stage_in_ctrl,
    output logic                  stage_out_ctrl,
    output logic                  sieve_ctrl,
    output logic [N_CHAMBERS-1:0] collect_ctrl,
    output logic [2:0]            pump,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Run counter counts clocks for LOAD/COLLECT/FLUSH and pump phases for
    // PUMP; two extra bits hold count*3 without wrapping at the maximum count.
    localparam int RUN_W = CNT_W + 2;
    localparam int PC_W  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int ST_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_PUMP    = 2'd1;
    localparam logic [1:0] OP_COLLECT = 2'd2;
    localparam logic [1:0] OP_FLUSH   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        op_reg, op_next;
    logic [7:0]        sel_reg, sel_next;
    logic [RUN_W-1:0]  run_cnt_reg, run_cnt_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic [1:0]        phase_reg, phase_next;
    logic [ST_W-1:0]   settle_reg, settle_next;
    logic              aborted_reg, aborted_next;

    logic [N_INLETS-1:0]   inlet_next;
    logic [N_CHAMBERS-1:0] collect_next;
    logic                  prep_inlet_next, prep_outlet_next;
    logic                  stage_in_next, stage_out_next, sieve_next;
    logic [2:0]            pump_next;
    logic                  ready_next, busy_next, done_next, err_next;

    logic [RUN_W-1:0]      cnt_ext, cnt_x3;
    logic                  cmd_bad, tick, run_open;
    logic [N_INLETS-1:0]   inlet_hit;
    logic [N_CHAMBERS-1:0] chamber_hit;

    assign cnt_ext = {2'b00, cmd_count};
    assign cnt_x3  = (cnt_ext << 1) + cnt_ext;

    assign cmd_bad = (cmd_count == '0)
                  || ((cmd_op == OP_LOAD)    && ({24'd0, cmd_sel} >= 32'(N_INLETS)))
                  || ((cmd_op == OP_COLLECT) && ({24'd0, cmd_sel} >= 32'(N_CHAMBERS)));

    // A counter tick is every clock for plain ops, end of each phase for PUMP.
    assign tick = (op_reg != OP_PUMP) || (pc_reg == PC_W'(PHASE_CYCLES - 1));

    // Decode the selector that will be in effect next cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N_INLETS; gi++) begin : g_inlet_dec
            assign inlet_hit[gi] = (sel_next == 8'(gi));
        end
        for (gi = 0; gi < N_CHAMBERS; gi++) begin : g_chamber_dec
            assign chamber_hit[gi] = (sel_next == 8'(gi));
        end
    endgenerate

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        sel_next     = sel_reg;
        run_cnt_next = run_cnt_reg;
        pc_next      = pc_reg;
        phase_next   = phase_reg;
        settle_next  = settle_reg;
        aborted_next = aborted_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        err_next = 1'b1;
                    end else begin
                        state_next   = S_RUN;
                        op_next      = cmd_op;
                        sel_next     = cmd_sel;
                        run_cnt_next = (cmd_op == OP_PUMP) ? cnt_x3 : cnt_ext;
                        pc_next      = '0;
                        phase_next   = 2'd0;
                        aborted_next = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_next   = S_DRAIN;
                    aborted_next = 1'b1;
                    settle_next  = ST_W'(SETTLE_CYCLES - 1);
                end else if (tick) begin
                    if (run_cnt_reg == RUN_W'(1)) begin
                        state_next  = S_DRAIN;
                        settle_next = ST_W'(SETTLE_CYCLES - 1);
                    end else begin
                        run_cnt_next = run_cnt_reg - RUN_W'(1);
                        pc_next      = '0;
                        phase_next   = (phase_reg == 2'd2) ? 2'd0 : phase_reg + 2'd1;
                    end
                end else begin
                    pc_next = pc_reg + PC_W'(1);
                end
            end
            S_DRAIN: begin
                if (settle_reg == '0) begin
                    state_next = S_IDLE;
                    done_next  = !aborted_reg;
                    err_next   = aborted_reg;
                end else begin
                    settle_next = settle_reg - ST_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase

        run_open         = (state_next == S_RUN);
        inlet_next       = ~(inlet_hit & {N_INLETS{run_open && (op_next == OP_LOAD)}});
        collect_next     = ~(chamber_hit & {N_CHAMBERS{run_open && (op_next == OP_COLLECT)}});
        prep_inlet_next  = !(run_open && (op_next == OP_LOAD));
        prep_outlet_next = !(run_open && (op_next == OP_FLUSH));
        stage_in_next    = !(run_open && (op_next == OP_PUMP));
        stage_out_next   = !(run_open && ((op_next == OP_PUMP) || (op_next == OP_FLUSH)));
        sieve_next       = !(run_open && (op_next == OP_COLLECT));
        pump_next        = 3'b111;
        if (run_open && (op_next == OP_PUMP)) begin
            case (phase_next)
                2'd0:    pump_next = 3'b110;
                2'd1:    pump_next = 3'b101;
                default: pump_next = 3'b011;
            endcase
        end
        ready_next = (state_next == S_IDLE);
        busy_next  = (state_next != S_IDLE);
    end

    // State and counter registers; reset returns to idle with counters cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            op_reg      <= OP_LOAD;
            sel_reg     <= '0;
            run_cnt_reg <= '0;
            pc_reg      <= '0;
            phase_reg   <= 2'd0;
            settle_reg  <= '0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            sel_reg     <= sel_next;
            run_cnt_reg <= run_cnt_next;
            pc_reg      <= pc_next;
            phase_reg   <= phase_next;
            settle_reg  <= settle_next;
            aborted_reg <= aborted_next;
        end
    end

    // Output registers; reset closes every valve at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inlet_ctrl       <= '1;
            prep_inlet_ctrl  <= 1'b1;
            prep_outlet_ctrl <= 1'b1;
            stage_in_ctrl    <= 1'b1;
            stage_out_ctrl   <= 1'b1;
            sieve_ctrl       <= 1'b1;
            collect_ctrl     <= '1;
            pump             <= 3'b111;
            cmd_ready        <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            inlet_ctrl       <= inlet_next;
            prep_inlet_ctrl  <= prep_inlet_next;
            prep_outlet_ctrl <= prep_outlet_next;
            stage_in_ctrl    <= stage_in_next;
            stage_out_ctrl   <= stage_out_next;
            sieve_ctrl       <= sieve_next;
            collect_ctrl     <= collect_next;
            pump             <= pump_next;
            cmd_ready        <= ready_next;
            busy             <= busy_next;
            done             <= done_next;
            err              <= err_next;
        end
    end

endmodule

// File: tb/tb_chip_valve_sequencer.sv
// Self-checking bench for chip_valve_sequencer: directed scenarios plus a
// randomized command stream compared against a cycle-indexed valve model.
module tb_chip_valve_sequencer;

    localparam int NI = 5;
    localparam int NC = 10;
    localparam int CW = 16;
    localparam int PC = 4;
    localparam int SC = 2;
    localparam int VW = NI + 5 + NC + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [7:0]    cmd_sel;
    logic [CW-1:0] cmd_count;
    logic          abort;
    logic [NI-1:0] inlet_ctrl;
    logic          prep_inlet_ctrl, prep_outlet_ctrl;
    logic          stage_in_ctrl, stage_out_ctrl, sieve_ctrl;
    logic [NC-1:0] collect_ctrl;
    logic [2:0]    pump;
    logic          busy, done, err;

    int total = 0;
    int bad   = 0;

    localparam logic [VW-1:0] ALL = '1;
    localparam logic [3:0] ST_IDLE = 4'b1000;  // {cmd_ready,busy,done,err}
    localparam logic [3:0] ST_BUSY = 4'b0100;
    localparam logic [3:0] ST_DONE = 4'b1010;
    localparam logic [3:0] ST_ERR  = 4'b1001;

    logic [VW-1:0] valves;
    logic [3:0]    status;
    assign valves = {inlet_ctrl, prep_inlet_ctrl, prep_outlet_ctrl, stage_in_ctrl,
                     stage_out_ctrl, sieve_ctrl, collect_ctrl, pump};
    assign status = {cmd_ready, busy, done, err};

    always #5 clk = ~clk;

    chip_valve_sequencer #(
        .N_INLETS(NI), .N_CHAMBERS(NC), .CNT_W(CW),
        .PHASE_CYCLES(PC), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_count(cmd_count), .abort(abort),
        .inlet_ctrl(inlet_ctrl), .prep_inlet_ctrl(prep_inlet_ctrl),
        .prep_outlet_ctrl(prep_outlet_ctrl), .stage_in_ctrl(stage_in_ctrl),
        .stage_out_ctrl(stage_out_ctrl), .sieve_ctrl(sieve_ctrl),
        .collect_ctrl(collect_ctrl), .pump(pump), .busy(busy), .done(done), .err(err)
    );

    // Expected open pattern for RUN clock k (1-based) of an operation.
    function automatic logic [VW-1:0] model_valves(input int op, input int sel, input int k);
        logic [NI-1:0] in_v;
        logic [NC-1:0] co_v;
        logic          pi, po, si, so, sv;
        logic [2:0]    p;
        in_v = '1; co_v = '1; pi = 1; po = 1; si = 1; so = 1; sv = 1; p = 3'b111;
        case (op)
            0: begin in_v[sel] = 1'b0; pi = 1'b0; end
            1: begin
                si = 1'b0; so = 1'b0;
                case (((k - 1) / PC) % 3)
                    0:       p = 3'b110;
                    1:       p = 3'b101;
                    default: p = 3'b011;
                endcase
            end
            2: begin co_v[sel] = 1'b0; sv = 1'b0; end
            default: begin po = 1'b0; so = 1'b0; end
        endcase
        return {in_v, pi, po, si, so, sv, co_v, p};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int op, input int sel, input int count);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_sel   = 8'(sel);
        cmd_count = CW'(count);
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        cmd_op = '0; cmd_sel = '0; cmd_count = '0;
        step(); step();
        total++;
        if (valves !== ALL || status !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state valves=%b status=%b want valves=%b status=%b", valves, status, ALL, ST_IDLE);
        end
        rst = 1'b0;
        step();
        present(1, 0, 2);
        step();
        cmd_valid = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        total++;
        if (valves !== ALL || pump !== 3'b111 || status !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_mid_pump valves=%b status=%b want valves=%b status=%b", valves, status, ALL, ST_IDLE);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (valves !== ALL || status !== ST_IDLE) begin
                bad++;
                $display("FAIL reset_after c=%0d valves=%b status=%b want status=%b", c, valves, status, ST_IDLE);
            end
        end
        $display("test_reset complete");
    endtask

    task automatic test_load();
        logic [VW-1:0] ev;
        logic [3:0]    es;
        present(0, 2, 5);
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            ev = (c <= 5) ? model_valves(0, 2, c) : ALL;
            es = (c <= 7) ? ST_BUSY : ST_DONE;
            total++;
            if (valves !== ev || status !== es) begin
                bad++;
                $display("FAIL load c=%0d valves=%b status=%b want valves=%b status=%b", c, valves, status, ev, es);
            end
            if (c == 1) begin
                total++;
                if (inlet_ctrl !== 5'b11011 || prep_inlet_ctrl !== 1'b0) begin
                    bad++;
                    $display("FAIL load_pattern inlet=%b prep_in=%b want 11011 0", inlet_ctrl, prep_inlet_ctrl);
                end
            end
            if (c < 8) step();
        end
        $display("test_load complete");
    endtask

    task automatic test_pump();
        logic [VW-1:0] ev;
        logic [3:0]    es;
        present(1, 0, 2);
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            ev = (c <= 24) ? model_valves(1, 0, c) : ALL;
            es = (c <= 26) ? ST_BUSY : ST_DONE;
            total++;
            if (valves !== ev || status !== es) begin
                bad++;
                $display("FAIL pump c=%0d pump=%b valves=%b status=%b want valves=%b status=%b", c, pump, valves, status, ev, es);
            end
            if (c < 27) step();
        end
        $display("test_pump complete");
    endtask

    task automatic test_collect();
        logic [VW-1:0] ev;
        logic [3:0]    es;
        present(2, 9, 3);
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            ev = (c <= 3) ? model_valves(2, 9, c) : ALL;
            es = (c <= 5) ? ST_BUSY : ST_DONE;
            total++;
            if (valves !== ev || status !== es) begin
                bad++;
                $display("FAIL collect c=%0d valves=%b status=%b want valves=%b status=%b", c, valves, status, ev, es);
            end
            if (c < 6) step();
        end
        $display("test_collect complete");
    endtask

    task automatic test_reject();
        int ops[3]  = '{2, 0, 0};
        int sels[3] = '{10, 1, 5};
        int cnts[3] = '{3, 0, 4};
        for (int i = 0; i < 3; i++) begin
            present(ops[i], sels[i], cnts[i]);
            step();
            cmd_valid = 1'b0;
            total++;
            if (valves !== ALL || status !== ST_ERR) begin
                bad++;
                $display("FAIL reject i=%0d valves=%b status=%b want valves=%b status=%b", i, valves, status, ALL, ST_ERR);
            end
            step();
            total++;
            if (status !== ST_IDLE) begin
                bad++;
                $display("FAIL reject_idle i=%0d status=%b want %b", i, status, ST_IDLE);
            end
        end
        $display("test_reject complete");
    endtask

    task automatic test_abort();
        logic [VW-1:0] ev;
        logic [3:0]    es;
        present(1, 0, 2);
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            ev = (c <= 10) ? model_valves(1, 0, c) : ALL;
            es = (c <= 12) ? ST_BUSY : ST_ERR;
            total++;
            if (valves !== ev || status !== es) begin
                bad++;
                $display("FAIL abort c=%0d valves=%b status=%b want valves=%b status=%b", c, valves, status, ev, es);
            end
            abort = (c == 10);
            if (c < 13) step();
        end
        abort = 1'b0;
        $display("test_abort complete");
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] ev;
        logic [3:0]    es;
        present(3, 0, 1);
        step();
        present(0, 0, 1);
        for (int c = 1; c <= 8; c++) begin
            if (c <= 1)      ev = model_valves(3, 0, c);
            else if (c == 5) ev = model_valves(0, 0, 1);
            else             ev = ALL;
            es = (c == 4 || c == 8) ? ST_DONE : ST_BUSY;
            total++;
            if (valves !== ev || status !== es) begin
                bad++;
                $display("FAIL back_to_back c=%0d valves=%b status=%b want valves=%b status=%b", c, valves, status, ev, es);
            end
            if (c == 4) begin
                step();
                cmd_valid = 1'b0;
            end else if (c < 8) begin
                step();
            end
        end
        $display("test_back_to_back complete");
    endtask

    task automatic test_random();
        int op, sel, cnt, len, stop, last, abort_at;
        bit valid, ab, aborted;
        logic [VW-1:0] ev;
        logic [3:0]    es;
        for (int n = 0; n < 30; n++) begin
            op  = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 11));
            cnt = ($urandom_range(0, 7) == 0) ? 0 :
                  ((op == 1) ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 8)));
            valid = (cnt != 0) && !(op == 0 && sel >= NI) && !(op == 2 && sel >= NC);
            len = (op == 1) ? cnt * 3 * PC : cnt;
            ab = ($urandom_range(0, 3) == 0);
            abort_at = int'($urandom_range(1, len + SC));
            aborted = valid && ab && (abort_at <= len);
            stop = aborted ? abort_at : len;
            last = valid ? stop + SC + 1 : 1;
            present(op, sel, cnt);
            abort = 1'($urandom_range(0, 1));
            total++;
            if (cmd_ready !== 1'b1) begin
                bad++;
                $display("FAIL rand_ready n=%0d got=%b want=1", n, cmd_ready);
            end
            step();
            cmd_valid = 1'b0;
            for (int c = 1; c <= last; c++) begin
                if (!valid) begin
                    ev = ALL; es = ST_ERR;
                end else if (c <= stop) begin
                    ev = model_valves(op, sel, c); es = ST_BUSY;
                end else if (c <= stop + SC) begin
                    ev = ALL; es = ST_BUSY;
                end else begin
                    ev = ALL; es = aborted ? ST_ERR : ST_DONE;
                end
                total++;
                if (valves !== ev || status !== es) begin
                    bad++;
                    $display("FAIL rand n=%0d op=%0d sel=%0d cnt=%0d c=%0d valves=%b status=%b want valves=%b status=%b",
                             n, op, sel, cnt, c, valves, status, ev, es);
                end
                abort = ab && (c >= abort_at) && (c < last);
                if (c < last) step();
            end
            abort = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                step();
                total++;
                if (status !== ST_IDLE || valves !== ALL) begin
                    bad++;
                    $display("FAIL rand_gap n=%0d status=%b valves=%b want status=%b", n, status, valves, ST_IDLE);
                end
            end
            $display("rand cmd n=%0d op=%0d sel=%0d cnt=%0d abort=%0d", n, op, sel, cnt, aborted);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_pump();
        test_collect();
        test_reject();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
